// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: data-hazard stalls, control flushes, post-reset blanking (optional HAZ_FWD_EN forwarding mode)
module hazard_ctrl #(
  parameter int AW        = 5,
  parameter int CTRL_PEN  = 3,
  parameter int RST_BLANK = 2
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic [AW-1:0] rr1,
  input  logic [AW-1:0] rr2,
  input  logic [AW-1:0] dr_ID_EX,
  input  logic [AW-1:0] dr_EX_MEM,
  input  logic [AW-1:0] dr_MEM_WB,
  input  logic          we_ID_EX,
  input  logic          we_EX_MEM,
  input  logic          we_MEM_WB,
  input  logic          ld_ID_EX,
  input  logic          Branch,
  input  logic          Jump,
  output logic          Stall_PC,
  output logic          Stall_IF_ID,
  output logic          Flush_IF_ID,
  output logic          Bubble_ID_EX,
  output logic          INRS,
  output logic          Busy,
  output logic [2:0]    Stall_cnt
);

  typedef enum logic [1:0] {INIT, RUN, DSTALL, CSTALL} state_t;

  // Counter reload values; the counter holds "cycles left after this one".
  localparam logic [2:0] CTRL_CNT   = 3'(CTRL_PEN - 1);
  localparam logic [1:0] BLANK_LAST = 2'(RST_BLANK - 1);

  state_t     r_state;
  logic [2:0] r_cnt;
  logic [1:0] r_blank;

  logic       w_hit_id_ex;
  logic       w_hit_ex_mem;
  logic       w_hit_mem_wb;
  logic [1:0] w_n;
  logic       w_unused;

  // Register 0 is hardwired, so a write to it can never create a dependency.
  assign w_hit_id_ex  = we_ID_EX  && (dr_ID_EX  != '0) && ((rr1 == dr_ID_EX)  || (rr2 == dr_ID_EX));
  assign w_hit_ex_mem = we_EX_MEM && (dr_EX_MEM != '0) && ((rr1 == dr_EX_MEM) || (rr2 == dr_EX_MEM));
  assign w_hit_mem_wb = we_MEM_WB && (dr_MEM_WB != '0) && ((rr1 == dr_MEM_WB) || (rr2 == dr_MEM_WB));

`ifdef HAZ_FWD_EN
  // Only a load-use dependency cannot be forwarded; it costs one bubble.
  assign w_n      = (w_hit_id_ex && ld_ID_EX) ? 2'd1 : 2'd0;
  assign w_unused = w_hit_ex_mem ^ w_hit_mem_wb;
`else
  // Without forwarding, the closer the producer, the longer the wait.
  assign w_n      = w_hit_id_ex  ? 2'd3 :
                    w_hit_ex_mem ? 2'd2 :
                    w_hit_mem_wb ? 2'd1 : 2'd0;
  assign w_unused = ld_ID_EX;
`endif

  assign Stall_cnt = r_cnt;

  // Hazard FSM with registered outputs, updated on the falling edge.
  always_ff @(negedge CLK) begin
    if (!RSTN) begin
      r_state      <= INIT;
      r_cnt        <= 3'd0;
      r_blank      <= 2'd0;
      Stall_PC     <= 1'b0;
      Stall_IF_ID  <= 1'b0;
      Flush_IF_ID  <= 1'b0;
      Bubble_ID_EX <= 1'b1;
      INRS         <= 1'b1;
      Busy         <= 1'b1;
    end else begin
      case (r_state)
        INIT: begin
          if (r_blank == BLANK_LAST) begin
            r_state      <= RUN;
            INRS         <= 1'b0;
            Busy         <= 1'b0;
            Bubble_ID_EX <= 1'b0;
          end else begin
            r_blank <= r_blank + 2'd1;
          end
        end
        RUN: begin
          if (Branch || Jump) begin
            r_state      <= CSTALL;
            r_cnt        <= CTRL_CNT;
            Stall_PC     <= 1'b0;
            Stall_IF_ID  <= 1'b0;
            Flush_IF_ID  <= 1'b1;
            Bubble_ID_EX <= 1'b1;
            Busy         <= 1'b1;
          end else if (w_n != 2'd0) begin
            r_state      <= DSTALL;
            r_cnt        <= {1'b0, w_n} - 3'd1;
            Stall_PC     <= 1'b1;
            Stall_IF_ID  <= 1'b1;
            Flush_IF_ID  <= 1'b0;
            Bubble_ID_EX <= 1'b1;
            Busy         <= 1'b1;
          end else begin
            Stall_PC     <= 1'b0;
            Stall_IF_ID  <= 1'b0;
            Flush_IF_ID  <= 1'b0;
            Bubble_ID_EX <= 1'b0;
            Busy         <= 1'b0;
          end
        end
        DSTALL, CSTALL: begin
          // Inputs are ignored here; the stall runs to completion.
          if (r_cnt == 3'd0) begin
            r_state      <= RUN;
            Stall_PC     <= 1'b0;
            Stall_IF_ID  <= 1'b0;
            Flush_IF_ID  <= 1'b0;
            Bubble_ID_EX <= 1'b0;
            Busy         <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter AW, default 5: register-address width.
REQ-002 SHALL have parameter CTRL_PEN, default 3, legal 1..7: bubbles inserted after a taken Branch/Jump.
REQ-003 SHALL have parameter RST_BLANK, default 2, legal 1..3: cycles INRS is held after reset release.
REQ-004 SHALL have the following ports:
- CLK  in  1  clock; all state updates on falling edge.
- RSTN  in  1  reset, synchronous, active-low.
- rr1, rr2  in  AW  ID-stage source register addresses.
- dr_ID_EX, dr_EX_MEM, dr_MEM_WB  in  AW  destination address per stage.
- we_ID_EX, we_EX_MEM, we_MEM_WB  in  1  stage writes its dr.
- ld_ID_EX  in  1  ID/EX instruction is a load.
- Branch, Jump  in  1  taken control transfer resolved this cycle.
- Stall_PC  out  1  hold PC.
- Stall_IF_ID  out  1  hold IF/ID register.
- Flush_IF_ID  out  1  clear IF/ID register to NOP.
- Bubble_ID_EX  out  1  insert NOP into ID/EX.
- INRS  out  1  pipeline-initialising indicator.
- Busy  out  1  FSM not in RUN.
- Stall_cnt  out  3  remaining stall/flush cycles.

Function
REQ-005 SHALL implement FSM states INIT, RUN, DSTALL and CSTALL, with a 3-bit down-counter cnt driving Stall_cnt.
REQ-006 SHALL define hit_k as (rr1==dr_k or rr2==dr_k) and we_k and dr_k!=0; register 0 never causes a hazard.
REQ-007 SHALL exit INIT after RST_BLANK falling edges into RUN with INRS=1 throughout INIT; INRS=0 in every other state.
REQ-008 SHALL, in RUN with Branch|Jump, go to CSTALL with cnt=CTRL_PEN-1 and assert Flush_IF_ID=1, Bubble_ID_EX=1, Stall_PC=0.
REQ-009 SHALL, in RUN without control transfer, select data stall length N by priority: hit_ID_EX gives 3, else hit_EX_MEM gives 2, else hit_MEM_WB gives 1.
REQ-010 SHALL, when N>0, go to DSTALL with cnt=N-1 and assert Stall_PC=1, Stall_IF_ID=1, Bubble_ID_EX=1.
REQ-011 SHALL give control hazards priority over data hazards when both occur in the same cycle.
REQ-012 SHALL decrement cnt each cycle in DSTALL/CSTALL with outputs held; at cnt==0 it SHALL return to RUN, deassert all stall/flush outputs, and re-evaluate hazards on the next edge.
REQ-013 SHALL ignore Branch, Jump and all hits while in DSTALL, CSTALL or INIT.
REQ-014 SHALL keep outputs registered, asserted from the detecting falling edge for exactly N (or CTRL_PEN) cycles.
REQ-015 SHALL keep Busy=1 in INIT, DSTALL and CSTALL; Stall_PC and Flush_IF_ID SHALL never be 1 simultaneously.

Reset
REQ-016 SHALL, when RSTN=0 at a falling edge, enter INIT with cnt=0, Stall_PC=0, Stall_IF_ID=0, Flush_IF_ID=0, Bubble_ID_EX=1, INRS=1, Busy=1.
REQ-017 SHALL have reset mid-stall abort DSTALL/CSTALL immediately, with no residual stall cycles after release.

Configuration
REQ-018 SHALL, with HAZ_FWD_EN defined, treat EX_MEM/MEM_WB hits and non-load ID_EX hits as forwarded (no stall); only hit_ID_EX and ld_ID_EX SHALL stall, with N=1.
REQ-019 SHALL, without HAZ_FWD_EN, ignore ld_ID_EX and apply the REQ-009 stall table.

Verification
REQ-020 SHALL cover reset: RSTN=0 for 2 edges then 1 -> INRS=1 for exactly 2 further edges, then Busy=0 with all stalls 0.
REQ-021 SHALL cover ID/EX data hazard: rr1=5, dr_ID_EX=5, we_ID_EX=1 -> Stall_PC/Stall_IF_ID/Bubble_ID_EX=1 for 3 cycles, Stall_cnt 2,1,0.
REQ-022 SHALL cover register 0: rr2=0, dr_EX_MEM=0, we_EX_MEM=1 -> no stall; then dr_MEM_WB=7, rr2=7, we_MEM_WB=1 -> 1-cycle stall.
REQ-023 SHALL cover control priority: Branch=1 together with an ID_EX hit, CTRL_PEN=3 -> Flush_IF_ID=1, Stall_PC=0 for 3 cycles; Jump=1 during that window ignored.
REQ-024 SHALL cover forwarding: with HAZ_FWD_EN, rr1=dr_ID_EX=4, we=1, ld_ID_EX=0 -> no stall; with ld_ID_EX=1 -> 1-cycle stall.
REQ-025 SHALL cover reset mid-stall: RSTN=0 in the 2nd cycle of a 3-cycle DSTALL -> INIT entered, Stall_PC=0 at that edge.
